// File: rtl/float_adder_pipe.sv
// float_adder_pipe: three-stage minifloat adder/subtractor with a valid/ready
// stream interface, round-to-nearest-even and overflow/inexact flags.
// Encoding is {sign, exp, man}. Every code is finite. exp==0 is subnormal.
// The exponent bias cancels out of an addition, so it only documents the format.
// A single global stall freezes every stage while the output is blocked.
module float_adder_pipe #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    parameter int BIAS  = 2**(EXP_W-1)-1,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         overflow,
    output logic         inexact
);

    // Significand with hidden bit, mantissa and guard/round/sticky bits.
    localparam int SW = MAN_W + 4;
    // Significand plus a carry bit.
    localparam int AW = SW + 1;
    // Exponent with headroom for the carry and rounding increments.
    localparam int EW = EXP_W + 2;

    logic stall;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // ------------------------------------------------------------------
    // Stage 1: unpack, order by magnitude, align the smaller operand
    // ------------------------------------------------------------------
    logic             sign_a, sign_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] man_a, man_b;
    logic             a_big;

    assign sign_a = a[W-1];
    assign sign_b = b[W-1] ^ sub;
    assign exp_a  = a[W-2:MAN_W];
    assign exp_b  = b[W-2:MAN_W];
    assign man_a  = a[MAN_W-1:0];
    assign man_b  = b[MAN_W-1:0];
    // With no Inf/NaN the magnitude order equals the unsigned order of {exp, man}.
    assign a_big  = (a[W-2:0] >= b[W-2:0]);

    logic             big_sign, sml_sign;
    logic [EXP_W-1:0] big_exp, sml_exp;
    logic [MAN_W-1:0] big_man, sml_man;
    logic [EXP_W-1:0] big_eff, sml_eff, exp_diff;
    logic [SW-1:0]    big_sig, sml_sig, sml_aligned;
    logic [2*SW-1:0]  sml_wide;

    // Swap operands so the larger magnitude comes first, then shift the smaller one right with sticky collection.
    always_comb begin
        if (a_big) begin
            big_sign = sign_a;
            big_exp  = exp_a;
            big_man  = man_a;
            sml_sign = sign_b;
            sml_exp  = exp_b;
            sml_man  = man_b;
        end else begin
            big_sign = sign_b;
            big_exp  = exp_b;
            big_man  = man_b;
            sml_sign = sign_a;
            sml_exp  = exp_a;
            sml_man  = man_a;
        end
        big_eff  = (big_exp == '0) ? EXP_W'(1) : big_exp;
        sml_eff  = (sml_exp == '0) ? EXP_W'(1) : sml_exp;
        exp_diff = big_eff - sml_eff;
        big_sig  = {(big_exp != '0), big_man, 3'b000};
        sml_sig  = {(sml_exp != '0), sml_man, 3'b000};
        sml_wide = {sml_sig, {SW{1'b0}}} >> exp_diff;
        if (int'(exp_diff) >= SW) begin
            sml_aligned = {{(SW-1){1'b0}}, |sml_sig};
        end else begin
            sml_aligned = sml_wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |sml_wide[SW-1:0]};
        end
    end

    logic             s1_valid, s1_sign, s1_sub;
    logic [EXP_W-1:0] s1_exp;
    logic [SW-1:0]    s1_big, s1_sml;

    // Stage 1 register: aligned operands, result sign and effective operation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_sub   <= 1'b0;
            s1_exp   <= '0;
            s1_big   <= '0;
            s1_sml   <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            s1_sign  <= big_sign;
            s1_sub   <= big_sign ^ sml_sign;
            s1_exp   <= big_eff;
            s1_big   <= big_sig;
            s1_sml   <= sml_aligned;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: significand add or subtract
    // ------------------------------------------------------------------
    logic [AW-1:0] sum_c;

    // The larger operand is always first, so subtraction never goes negative.
    always_comb begin
        if (s1_sub) begin
            sum_c = {1'b0, s1_big} - {1'b0, s1_sml};
        end else begin
            sum_c = {1'b0, s1_big} + {1'b0, s1_sml};
        end
    end

    logic             s2_valid, s2_sign, s2_sub;
    logic [EXP_W-1:0] s2_exp;
    logic [AW-1:0]    s2_sum;

    // Stage 2 register: raw sum with carry, exponent and sign.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_sub   <= 1'b0;
            s2_exp   <= '0;
            s2_sum   <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_sub   <= s1_sub;
            s2_exp   <= s1_exp;
            s2_sum   <= sum_c;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: normalise, round to nearest even, pack, saturate
    // ------------------------------------------------------------------
    logic [SW-1:0]    pre_m, norm_m;
    logic [EW-1:0]    pre_e, norm_e, fin_e;
    int               lz, lim, sh;
    logic             round_up;
    logic [MAN_W+1:0] rounded;
    logic [MAN_W:0]   fin_sig;
    logic [EXP_W-1:0] pack_exp;
    logic             ovf, inx;
    logic [W-1:0]     res_y;

    // Normalise the sum without pushing the exponent below 1, then round, pack and apply saturation or zero rules.
    always_comb begin
        pre_m = s2_sum[SW-1:0];
        pre_e = {2'b00, s2_exp};
        if (s2_sum[AW-1]) begin
            pre_m = {s2_sum[AW-1:2], |s2_sum[1:0]};
            pre_e = {2'b00, s2_exp} + EW'(1);
        end
        lz = SW;
        for (int i = 0; i < SW; i++) begin
            if (pre_m[i]) begin
                lz = SW - 1 - i;
            end
        end
        lim = int'(pre_e) - 1;
        sh  = (lz < lim) ? lz : lim;
        if (sh < 0) begin
            sh = 0;
        end
        norm_m   = pre_m << sh;
        norm_e   = pre_e - EW'(sh);
        round_up = norm_m[2] & (norm_m[3] | (|norm_m[1:0]));
        rounded  = {1'b0, norm_m[SW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
        fin_sig  = rounded[MAN_W:0];
        fin_e    = norm_e;
        if (rounded[MAN_W+1]) begin
            fin_sig = rounded[MAN_W+1:1];
            fin_e   = norm_e + EW'(1);
        end
        pack_exp = fin_sig[MAN_W] ? fin_e[EXP_W-1:0] : '0;
        ovf      = |fin_e[EW-1:EXP_W];
        inx      = (|norm_m[2:0]) | ovf;
        res_y    = {s2_sign, pack_exp, fin_sig[MAN_W-1:0]};
        if (ovf) begin
            res_y = {s2_sign, {(EXP_W+MAN_W){1'b1}}};
        end
        if (s2_sum == '0) begin
            res_y = {s2_sign & ~s2_sub, {(EXP_W+MAN_W){1'b0}}};
            ovf   = 1'b0;
            inx   = 1'b0;
        end
    end

    // Output register: holds the result and flags steady while downstream stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            overflow  <= 1'b0;
            inexact   <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_valid;
            y         <= res_y;
            overflow  <= ovf;
            inexact   <= inx;
        end
    end

endmodule

// File: tb/tb_float_adder_pipe.sv
// tb_float_adder_pipe: directed scoreboard bench for float_adder_pipe
// (default E4M3 instance plus an E5M2 instance).
module tb_float_adder_pipe;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       in_valid, in_ready, sub, out_valid, out_ready, overflow, inexact;
    logic [7:0] a, b, y;

    logic       alt_in_valid, alt_in_ready, alt_sub, alt_out_valid, alt_out_ready;
    logic       alt_overflow, alt_inexact;
    logic [7:0] alt_a, alt_b, alt_y;

    typedef struct {
        string      tag;
        logic [7:0] y;
        logic       ov;
        logic       inx;
        int         lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    float_adder_pipe dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .overflow  (overflow),
        .inexact   (inexact)
    );

    float_adder_pipe #(.EXP_W(5), .MAN_W(2)) dut_alt (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (alt_in_valid),
        .in_ready  (alt_in_ready),
        .a         (alt_a),
        .b         (alt_b),
        .sub       (alt_sub),
        .out_valid (alt_out_valid),
        .out_ready (alt_out_ready),
        .y         (alt_y),
        .overflow  (alt_overflow),
        .inexact   (alt_inexact)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Cycle counter used for latency expectations.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Drive one operation and wait (bounded) until it is accepted, then record its expected result.
    task automatic applyStimulus(input string tag, input logic [7:0] av, input logic [7:0] bv,
                                 input logic sb, input logic [7:0] ey, input logic eo,
                                 input logic ei, input logic chk_lat);
        logic acc;
        int   waits;
        acc      = 1'b0;
        waits    = 0;
        a        = av;
        b        = bv;
        sub      = sb;
        in_valid = 1'b1;
        while (!acc && waits < 50) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            waits++;
        end
        if (acc) begin
            sb_q.push_back('{tag, ey, eo, ei, (chk_lat ? cyc + 2 : -1)});
        end else begin
            checkOutput({tag, "_accept_timeout"}, 32'(acc), 32'd1);
        end
    endtask

    task automatic drainQueue(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        checkOutput({tag, "_drained"}, sb_q.size(), 0);
    endtask

    // One operation on the E5M2 instance, checked on its output with a bounded wait.
    task automatic altOp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic sb, input logic [7:0] ey, input logic eo, input logic ei);
        logic seen;
        int   n;
        seen         = 1'b0;
        n            = 0;
        alt_a        = av;
        alt_b        = bv;
        alt_sub      = sb;
        alt_in_valid = 1'b1;
        @(posedge clock);
        #1;
        alt_in_valid = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clock);
            seen = alt_out_valid;
            n++;
        end
        checkOutput({tag, "_valid"}, 32'(seen), 32'd1);
        checkOutput({tag, "_lat"}, n, 3);
        checkOutput({tag, "_y"}, alt_y, ey);
        checkOutput({tag, "_ovf"}, alt_overflow, eo);
        checkOutput({tag, "_inx"}, alt_inexact, ei);
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: pop and compare every result handed downstream.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            vectors++;
            assert (sb_q.size() != 0) else begin
                miscompares++;
                $error("[TB] FAIL spurious_output: observed y=0x%0h required no output", y);
            end
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                checkOutput({mon_e.tag, "_y"}, y, mon_e.y);
                checkOutput({mon_e.tag, "_ovf"}, overflow, mon_e.ov);
                checkOutput({mon_e.tag, "_inx"}, inexact, mon_e.inx);
                if (mon_e.lat >= 0) begin
                    checkOutput({mon_e.tag, "_lat"}, cyc, mon_e.lat);
                end
            end
        end
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        reset_n       = 1'b0;
        in_valid      = 1'b0;
        a             = '0;
        b             = '0;
        sub           = 1'b0;
        out_ready     = 1'b1;
        alt_in_valid  = 1'b0;
        alt_a         = '0;
        alt_b         = '0;
        alt_sub       = 1'b0;
        alt_out_ready = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_y", y, 0);
        checkOutput("reset_ovf", overflow, 0);
        checkOutput("reset_inx", inexact, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("in_ready_after_reset", in_ready, 1);

        $display("[TB] directed operations, out_ready held high");
        applyStimulus("add_2p2",     8'h40, 8'h40, 1'b0, 8'h48, 1'b0, 1'b0, 1'b1);
        applyStimulus("add_exact",   8'h28, 8'h10, 1'b0, 8'h29, 1'b0, 1'b0, 1'b1);
        applyStimulus("add_sticky",  8'h50, 8'h10, 1'b0, 8'h50, 1'b0, 1'b1, 1'b1);
        applyStimulus("tie_even",    8'h40, 8'h20, 1'b0, 8'h40, 1'b0, 1'b1, 1'b1);
        applyStimulus("tie_up",      8'h41, 8'h20, 1'b0, 8'h42, 1'b0, 1'b1, 1'b1);
        applyStimulus("sub_zero",    8'h40, 8'h40, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus("sub_pos",     8'h48, 8'h40, 1'b1, 8'h40, 1'b0, 1'b0, 1'b1);
        applyStimulus("sub_neg",     8'h40, 8'h48, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b1);
        applyStimulus("mixed_sign",  8'h48, 8'hC0, 1'b0, 8'h40, 1'b0, 1'b0, 1'b1);
        applyStimulus("subnormal",   8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
        applyStimulus("sub_to_norm", 8'h07, 8'h01, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1);
        applyStimulus("sat_pos",     8'h7F, 8'h7F, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b1);
        applyStimulus("sat_neg",     8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1);
        applyStimulus("negzero_add", 8'h80, 8'h80, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
        applyStimulus("negzero_sub", 8'h80, 8'h80, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        drainQueue("directed");

        $display("[TB] backpressure: six ops, out_ready low for four cycles");
        fork
            begin
                applyStimulus("bp0", 8'h40, 8'h40, 1'b0, 8'h48, 1'b0, 1'b0, 1'b0);
                applyStimulus("bp1", 8'h28, 8'h10, 1'b0, 8'h29, 1'b0, 1'b0, 1'b0);
                applyStimulus("bp2", 8'h41, 8'h20, 1'b0, 8'h42, 1'b0, 1'b1, 1'b0);
                applyStimulus("bp3", 8'h48, 8'h40, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
                applyStimulus("bp4", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
                applyStimulus("bp5", 8'h7F, 8'h7F, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clock);
                #1;
                out_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clock);
                    checkOutput("bp_in_ready", in_ready, 0);
                    checkOutput("bp_out_valid", out_valid, 1);
                    if (sb_q.size() != 0) begin
                        checkOutput("bp_y_held", y, sb_q[0].y);
                    end
                end
                @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        drainQueue("backpressure");

        $display("[TB] reset with operations in flight");
        applyStimulus("rst0", 8'h40, 8'h40, 1'b0, 8'h48, 1'b0, 1'b0, 1'b0);
        applyStimulus("rst1", 8'h28, 8'h10, 1'b0, 8'h29, 1'b0, 1'b0, 1'b0);
        applyStimulus("rst2", 8'h50, 8'h10, 1'b0, 8'h50, 1'b0, 1'b1, 1'b0);
        #1;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_y", y, 0);
        sb_q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checkOutput("rst_no_stale", out_valid, 0);
        end
        @(posedge clock);
        #1;
        applyStimulus("post_reset", 8'h41, 8'h20, 1'b0, 8'h42, 1'b0, 1'b1, 1'b1);
        in_valid = 1'b0;
        drainQueue("post_reset");

        $display("[TB] E5M2 instance");
        altOp("alt_add",  8'h40, 8'h40, 1'b0, 8'h44, 1'b0, 1'b0);
        altOp("alt_swap", 8'h3C, 8'h40, 1'b0, 8'h42, 1'b0, 1'b0);
        altOp("alt_zero", 8'h40, 8'h40, 1'b1, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
